// File: rtl/serial_pkg.sv
// Shared definitions for the byte serializer and its deserializer counterpart:
// the FSM state encoding and the default framing constants.
package serial_pkg;

  // Serializer FSM states, in byte-period order.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Default framing constants, shared so that both ends of a loopback agree.
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_LEN_WIDTH   = 4;
  localparam int DEF_HALF_CYCLES = 10;
  localparam int DEF_GAP_CYCLES  = 300;

endpackage

// File: rtl/bit_timer.sv
// Loadable down-counter with a terminal-count pulse. The counter decrements
// while enabled and parks at zero; tc_out is high for each enabled cycle in
// which the count is zero. A load takes priority over counting.
module bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_value_in,
  input  logic             enable_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load, else decrement towards zero while enabled.
  always_comb begin
    count_d = count_q;
    if (load_in) begin
      count_d = load_value_in;
    end else if (enable_in && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;
  assign tc_out    = enable_in && (count_q == '0);

endmodule

// File: rtl/byte_serializer.sv
// Drains a byte queue and emits each popped byte MSB-first as a strobed
// serial stream: per bit, write_out is high for HALF_CYCLES and low for
// HALF_CYCLES while serial_out holds the bit; each byte is followed by
// GAP_CYCLES of silence before the queue is looked at again.
//
// Queue handshake: dequeue_out is a one-cycle pop request. The queue pops on
// the rising edge that ends the cycle in which dequeue_out is high; data_in
// must hold the head word on that same edge, which is when it is captured.
// A pop is only requested from IDLE with enable_in = 1 and len_in != 0, so
// dequeue_out is never high on two consecutive cycles.
module byte_serializer
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int HALF_CYCLES = DEF_HALF_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable_in,
  input  logic [LEN_WIDTH-1:0]                len_in,
  input  logic [DATA_WIDTH-1:0]               data_in,
  output logic                                dequeue_out,
  output logic                                serial_out,
  output logic                                write_out,
  output logic                                busy_out,
  output logic [7:0]                          sent_count_out,
  output state_e                              dbg_state_out,
  output logic [$clog2(GAP_CYCLES+1)-1:0]     dbg_gap_count_out
);

  localparam int BIT_TW = $clog2(2 * HALF_CYCLES);
  localparam int GAP_TW = $clog2(GAP_CYCLES + 1);
  localparam int IDX_W  = $clog2(DATA_WIDTH);

  // The bit timer counts a bit period down from 2*HALF_CYCLES-1 to 0; the
  // first HALF_CYCLES counts of that range are the strobe-high half.
  localparam logic [BIT_TW-1:0] BIT_LOAD = BIT_TW'(2 * HALF_CYCLES - 1);
  localparam logic [BIT_TW-1:0] HALF_V   = BIT_TW'(HALF_CYCLES);
  localparam logic [GAP_TW-1:0] GAP_LOAD = GAP_TW'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_e                  state_q,   state_d;
  logic [DATA_WIDTH-1:0]   shift_q,   shift_d;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic [7:0]              sent_q,    sent_d;
  logic                    deq_q,     deq_d;
  logic                    serial_q,  serial_d;
  logic                    write_q,   write_d;
  logic                    busy_q,    busy_d;

  logic                    bit_load;
  logic                    bit_tc;
  logic [BIT_TW-1:0]       bit_count;
  logic                    gap_load;
  logic                    gap_tc;
  logic [GAP_TW-1:0]       gap_count;

  // Bit-period timer: runs only while sending, reloaded at every bit start.
  bit_timer #(
    .WIDTH (BIT_TW)
  ) u_bit_timer (
    .clock         (clock),
    .reset         (reset),
    .load_in       (bit_load),
    .load_value_in (BIT_LOAD),
    .enable_in     (state_q == SEND),
    .count_out     (bit_count),
    .tc_out        (bit_tc)
  );

  // Inter-byte gap timer: loaded when the last bit completes.
  bit_timer #(
    .WIDTH (GAP_TW)
  ) u_gap_timer (
    .clock         (clock),
    .reset         (reset),
    .load_in       (gap_load),
    .load_value_in (GAP_LOAD),
    .enable_in     (state_q == GAP),
    .count_out     (gap_count),
    .tc_out        (gap_tc)
  );

  // Next-state logic; outputs are derived from the next state so that every
  // output leaves a flop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    sent_d    = sent_q;
    deq_d     = 1'b0;
    bit_load  = 1'b0;
    gap_load  = 1'b0;

    case (state_q)
      IDLE: begin
        // Enable and occupancy are only looked at here.
        if (enable_in && (len_in != '0)) begin
          state_d = POP;
          deq_d   = 1'b1;
        end
      end
      POP: begin
        // The queue pops on this edge; capture its head at the same time.
        state_d   = SEND;
        shift_d   = data_in;
        bit_idx_d = '0;
        bit_load  = 1'b1;
      end
      SEND: begin
        if (bit_tc) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          if (bit_idx_q == LAST_IDX) begin
            state_d   = GAP;
            gap_load  = 1'b1;
            bit_idx_d = '0;
            sent_d    = sent_q + 8'd1;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            bit_load  = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_tc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d   = (state_d != IDLE);
    serial_d = (state_d == SEND) ? shift_d[DATA_WIDTH-1] : 1'b0;

    // Strobe for the coming cycle: high on the first cycle of a bit, and
    // otherwise while the decremented count is still in the upper half.
    write_d = 1'b0;
    if (state_d == SEND) begin
      if (bit_load) begin
        write_d = 1'b1;
      end else begin
        write_d = (bit_count > HALF_V);
      end
    end
  end

  // FSM, shift register, byte counter and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      sent_q    <= '0;
      deq_q     <= 1'b0;
      serial_q  <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      sent_q    <= sent_d;
      deq_q     <= deq_d;
      serial_q  <= serial_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
    end
  end

  assign dequeue_out       = deq_q;
  assign serial_out        = serial_q;
  assign write_out         = write_q;
  assign busy_out          = busy_q;
  assign sent_count_out    = sent_q;
  assign dbg_state_out     = state_q;
  assign dbg_gap_count_out = gap_count;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: a queue model feeds the DUT, an expected-byte
// queue tracks what must come out, and each serialized byte is compared
// cycle by cycle against a waveform computed from the framing rules.
module tb_byte_serializer;
  import serial_pkg::*;

  localparam int DW      = DEF_DATA_WIDTH;
  localparam int LW      = DEF_LEN_WIDTH;
  localparam int H       = DEF_HALF_CYCLES;
  localparam int GAPC    = DEF_GAP_CYCLES;
  localparam int BIT_P   = 2 * H;
  localparam int SEND_L  = DW * BIT_P;
  localparam int BYTE_P  = SEND_L + GAPC + 2;
  localparam int LAST_K  = SEND_L + GAPC + 1;
  localparam int GTW     = $clog2(GAPC + 1);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic          enable_in;
  logic [LW-1:0] len_in  = '0;
  logic [DW-1:0] data_in = '0;
  logic          dequeue_out, serial_out, write_out, busy_out;
  logic [7:0]    sent_count_out;
  state_e        dbg_state_out;
  logic [GTW-1:0] dbg_gap_count_out;

  byte_serializer dut (
    .clock             (clock),
    .reset             (reset),
    .enable_in         (enable_in),
    .len_in            (len_in),
    .data_in           (data_in),
    .dequeue_out       (dequeue_out),
    .serial_out        (serial_out),
    .write_out         (write_out),
    .busy_out          (busy_out),
    .sent_count_out    (sent_count_out),
    .dbg_state_out     (dbg_state_out),
    .dbg_gap_count_out (dbg_gap_count_out)
  );

  // ---------------- queue model and scoreboard ----------------
  logic [DW-1:0] feed_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] feed_dummy;
  logic [7:0]    model_sent = '0;
  logic          pop_pending = 1'b0;
  int errors = 0;
  int checks = 0;

  // Queue model: the pop requested in one cycle takes effect at the edge
  // that ends it, so the head advances at the following negedge.
  always @(negedge clock) begin
    if (!reset) begin
      pop_pending = 1'b0;
    end else begin
      if (pop_pending && feed_q.size() > 0) feed_dummy = feed_q.pop_front();
      pop_pending = dequeue_out;
    end
    len_in  = (feed_q.size() > (1 << LW) - 1) ? LW'((1 << LW) - 1) : LW'(feed_q.size());
    data_in = (feed_q.size() > 0) ? feed_q[0] : '0;
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [DW-1:0] b);
    feed_q.push_back(b);
    exp_q.push_back(b);
  endtask

  function automatic logic [DW-1:0] next_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return '0;
  endfunction

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    feed_q.delete();
    exp_q.delete();
    model_sent = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_pop(input int budget, output int waited, output bit found);
    found  = 1'b0;
    waited = 0;
    while (!found && waited < budget) begin
      @(negedge clock);
      waited++;
      if (dequeue_out === 1'b1) found = 1'b1;
    end
  endtask

  // Called at the negedge inside the POP cycle (k = 0). Walks k = 1..LAST_K
  // and compares every cycle with the waveform the framing rules give.
  task automatic run_byte(input logic [DW-1:0] b, input int drop_en_k,
                          output int bad, output int first_bad,
                          output logic [DW-1:0] decoded, output int pulses);
    logic exp_w, exp_s, exp_b, wr_prev;
    logic [7:0] exp_sent;
    bad = 0; first_bad = -1; decoded = '0; pulses = 0; wr_prev = 1'b0;
    for (int k = 1; k <= LAST_K; k++) begin
      @(negedge clock);
      if (k == drop_en_k) enable_in = 1'b0;
      if (k <= SEND_L) begin
        exp_w = (((k - 1) % BIT_P) < H);
        exp_s = b[DW - 1 - ((k - 1) / BIT_P)];
        exp_b = 1'b1;
      end else begin
        exp_w = 1'b0;
        exp_s = 1'b0;
        exp_b = (k < LAST_K);
      end
      exp_sent = (k > SEND_L) ? model_sent + 8'd1 : model_sent;
      if (write_out === 1'b1 && wr_prev !== 1'b1) begin
        decoded = {decoded[DW-2:0], serial_out};
        pulses++;
      end
      wr_prev = write_out;
      if ({dequeue_out, serial_out, write_out, busy_out} !== {1'b0, exp_s, exp_w, exp_b} ||
          sent_count_out !== exp_sent) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    model_sent = model_sent + 8'd1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    enable_in = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i));
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if ({dequeue_out, serial_out, write_out, busy_out} !== 4'b0000 ||
          sent_count_out !== 8'd0 || dbg_state_out !== IDLE) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL reset_hold: %0d bad cycles, required 0", bad); end
    checks++;
    if (len_in !== 4'd5) begin errors++; $display("FAIL reset_len: len_in=%0d required 5", len_in); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (dequeue_out !== 1'b1) begin errors++; $display("FAIL reset_first_pop: dequeue_out=%b required 1", dequeue_out); end
    // Abort before the capture edge and start clean.
    #1 reset = 1'b0;
    feed_q.delete();
    exp_q.delete();
    model_sent = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_abort_busy: busy_out=%b required 0", busy_out); end
    reset = 1'b1;
  endtask

  task automatic test_single_byte();
    int bad, first_bad, pulses, waited, extra;
    bit found;
    logic [DW-1:0] dec, b;
    enable_in = 1'b1;
    push_byte(8'hA5);
    wait_pop(20, waited, found);
    checks++;
    if (!found) begin errors++; $display("FAIL single_pop: no dequeue within %0d cycles", waited); end
    b = next_exp();
    run_byte(b, 0, bad, first_bad, dec, pulses);
    checks++;
    if (dec !== b) begin errors++; $display("FAIL single_data: got %h required %h", dec, b); end
    checks++;
    if (pulses !== DW) begin errors++; $display("FAIL single_pulses: got %0d required %0d", pulses, DW); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL single_wave: %0d bad cycles, first at k=%0d, required 0", bad, first_bad); end
    checks++;
    if (sent_count_out !== 8'd1) begin errors++; $display("FAIL single_sent: got %0d required 1", sent_count_out); end
    extra = 0;
    repeat (50) begin
      @(negedge clock);
      if (dequeue_out !== 1'b0 || busy_out !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL single_after: %0d active cycles, required 0", extra); end
  endtask

  task automatic test_back_to_back();
    int bad, first_bad, pulses, waited, last_pop;
    bit found;
    logic [DW-1:0] dec, b;
    apply_reset();
    enable_in = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
    last_pop = 0;
    for (int i = 0; i < 8; i++) begin
      wait_pop(BYTE_P + 10, waited, found);
      checks++;
      if (!found) begin errors++; $display("FAIL b2b_pop%0d: no dequeue within %0d cycles", i, waited); end
      if (i > 0) begin
        checks++;
        if (cyc - last_pop !== BYTE_P) begin
          errors++; $display("FAIL b2b_period%0d: got %0d cycles required %0d", i, cyc - last_pop, BYTE_P);
        end
      end
      last_pop = cyc;
      b = next_exp();
      run_byte(b, 0, bad, first_bad, dec, pulses);
      checks++;
      if (dec !== b) begin errors++; $display("FAIL b2b_data%0d: got %h required %h", i, dec, b); end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL b2b_wave%0d: %0d bad cycles, first at k=%0d", i, bad, first_bad); end
    end
    checks++;
    if (sent_count_out !== 8'd8) begin errors++; $display("FAIL b2b_sent: got %0d required 8", sent_count_out); end
  endtask

  task automatic test_empty_disable();
    int bad, first_bad, pulses, waited, deqs, busys;
    bit found;
    logic [DW-1:0] dec, b;
    apply_reset();
    enable_in = 1'b1;
    deqs = 0; busys = 0;
    repeat (1000) begin
      @(negedge clock);
      if (dequeue_out !== 1'b0) deqs++;
      if (busy_out !== 1'b0) busys++;
    end
    checks++;
    if (deqs !== 0) begin errors++; $display("FAIL empty_deq: %0d pulses required 0", deqs); end
    checks++;
    if (busys !== 0) begin errors++; $display("FAIL empty_busy: %0d busy cycles required 0", busys); end
    push_byte(8'h3C);
    push_byte(8'h5A);
    wait_pop(20, waited, found);
    checks++;
    if (!found) begin errors++; $display("FAIL dis_pop: no dequeue within %0d cycles", waited); end
    b = next_exp();
    // Drop enable at the first cycle of bit 3.
    run_byte(b, 3 * BIT_P + 1, bad, first_bad, dec, pulses);
    checks++;
    if (dec !== b) begin errors++; $display("FAIL dis_data: got %h required %h", dec, b); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL dis_wave: %0d bad cycles, first at k=%0d", bad, first_bad); end
    deqs = 0; busys = 0;
    repeat (500) begin
      @(negedge clock);
      if (dequeue_out !== 1'b0) deqs++;
      if (busy_out !== 1'b0) busys++;
    end
    checks++;
    if (deqs !== 0 || busys !== 0) begin
      errors++; $display("FAIL dis_hold: deq=%0d busy=%0d required 0 0", deqs, busys);
    end
    enable_in = 1'b1;
    wait_pop(5, waited, found);
    checks++;
    if (!found) begin errors++; $display("FAIL reen_pop: no dequeue within %0d cycles", waited); end
    b = next_exp();
    run_byte(b, 0, bad, first_bad, dec, pulses);
    checks++;
    if (dec !== b || bad !== 0) begin
      errors++; $display("FAIL reen_byte: got %h bad=%0d required %h bad=0", dec, bad, b);
    end
  endtask

  task automatic test_mid_reset();
    int bad, first_bad, pulses, waited, strobes;
    bit found;
    logic [DW-1:0] dec, b;
    apply_reset();
    enable_in = 1'b1;
    push_byte(8'hFF);
    wait_pop(20, waited, found);
    b = next_exp();  // this byte is lost by the reset
    repeat (5 * BIT_P + 4) @(negedge clock);
    checks++;
    if (!found || write_out !== 1'b1 || serial_out !== 1'b1) begin
      errors++; $display("FAIL mid_active: found=%0d write=%b serial=%b required 1 1 1", found, write_out, serial_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({dequeue_out, serial_out, write_out, busy_out} !== 4'b0000) begin
      errors++; $display("FAIL mid_async: deq/ser/wr/busy=%b required 0000",
                         {dequeue_out, serial_out, write_out, busy_out});
    end
    checks++;
    if (sent_count_out !== 8'd0) begin errors++; $display("FAIL mid_sent: got %0d required 0", sent_count_out); end
    strobes = 0;
    repeat (3) begin
      @(negedge clock);
      if (write_out !== 1'b0) strobes++;
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL mid_strobes: %0d required 0", strobes); end
    reset = 1'b1;
    model_sent = '0;
    push_byte(8'h96);
    wait_pop(20, waited, found);
    checks++;
    if (!found) begin errors++; $display("FAIL mid_repop: no dequeue within %0d cycles", waited); end
    b = next_exp();
    run_byte(b, 0, bad, first_bad, dec, pulses);
    checks++;
    if (dec !== b || bad !== 0) begin
      errors++; $display("FAIL mid_next: got %h bad=%0d first=%0d required %h bad=0", dec, bad, first_bad, b);
    end
  endtask

  task automatic test_random_stream();
    int bad, first_bad, pulses, waited, idle;
    bit found;
    logic [DW-1:0] dec, b;
    enable_in = 1'b1;
    for (int n = 0; n < 4; n++) begin
      idle = $urandom_range(0, 40);
      repeat (idle) @(negedge clock);
      push_byte(DW'($urandom_range(0, 255)));
      wait_pop(20, waited, found);
      checks++;
      if (!found) begin errors++; $display("FAIL rand_pop%0d: no dequeue within %0d cycles", n, waited); end
      b = next_exp();
      run_byte(b, 0, bad, first_bad, dec, pulses);
      checks++;
      if (dec !== b || bad !== 0) begin
        errors++; $display("FAIL rand_byte%0d: got %h bad=%0d first=%0d required %h bad=0", n, dec, bad, first_bad, b);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    enable_in = 1'b0;
    #1 reset = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty_disable();
    test_mid_reset();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Drain stage directly downstream of the 8-entry byte queue.
- Pops one byte whenever the queue is non-empty and emits it MSB-first as a serial bit stream, one bit per write strobe.
- Output framing is identical to the deserializer's input protocol, so a loopback bench can drive the deserializer directly.
- Runs in the queue's clock domain; any clock-domain crossing is handled outside this block.

Parameters:
- DATA_WIDTH, 8, byte width; must match the queue word width.
- LEN_WIDTH, 4, width of the queue occupancy input.
- HALF_CYCLES, 10, clock cycles write_out stays high per bit, then the same count low (20-cycle bit period).
- GAP_CYCLES, 300, idle cycles inserted after each byte before the next pop.

Ports:
- clock, input, 1, sole clock, rising edge.
- reset, input, 1, asynchronous, active-low; 0 = in reset.
- enable_in, input, 1, 1 = draining allowed; sampled only in IDLE.
- len_in, input, LEN_WIDTH, queue occupancy.
- data_in, input, DATA_WIDTH, queue head word; valid whenever len_in != 0.
- dequeue_out, output, 1, one-cycle pop request to the queue.
- serial_out, output, 1, current bit; stable for the whole bit period.
- write_out, output, 1, bit strobe; high for the first HALF_CYCLES of each bit.
- busy_out, output, 1, high in every state except IDLE.
- sent_count_out, output, 8, completed bytes since reset; wraps 255 -> 0.

Behaviour:
- Reset (reset = 0, asynchronous) forces:
  - outputs: dequeue_out = 0, serial_out = 0, write_out = 0, busy_out = 0, sent_count_out = 0;
  - internal: state = IDLE, shift register = 0, bit counter = 0, timers = 0.
- Reset asserted mid-byte aborts the byte immediately. The popped byte is lost and is not counted. No further strobes occur after reset.
- All outputs are registered.
- IDLE:
  - if enable_in = 1 and len_in != 0 -> POP;
  - otherwise stay in IDLE.
- POP (exactly 1 cycle):
  - dequeue_out = 1;
  - shift register <= data_in (head captured on the same edge as the pop);
  - bit counter <= 0, bit timer <= 0;
  - -> SEND.
- SEND:
  - serial_out = shift register MSB;
  - write_out = 1 while bit timer < HALF_CYCLES, 0 for the remaining HALF_CYCLES;
  - when bit timer = 2*HALF_CYCLES-1: timer <= 0, shift left by 1, bit counter + 1;
  - after bit DATA_WIDTH-1 completes: sent_count_out + 1 -> GAP.
- GAP:
  - serial_out = 0, write_out = 0;
  - count GAP_CYCLES, then -> IDLE.
- Latency: the first write_out rising edge occurs 1 cycle after dequeue_out pulses.
- Byte duration: DATA_WIDTH*2*HALF_CYCLES cycles, plus GAP_CYCLES, plus 1 POP cycle and 1 IDLE cycle. Default: 160 + 300 + 2 = 462 cycles per byte.
- Empty queue (len_in = 0): never pulse dequeue_out; hold IDLE.
- Full queue: no special case; drain one byte per period.
- enable_in dropping mid-byte does not abort. The current byte and its gap complete; the block then waits in IDLE.
- len_in changing while in SEND/GAP is ignored. Occupancy is re-evaluated only in IDLE.
- dequeue_out is never high for 2 consecutive cycles.
- At most one pop is issued per byte period.
- Timer widths: $clog2(2*HALF_CYCLES) and $clog2(GAP_CYCLES+1).
- Bit counter width: $clog2(DATA_WIDTH).
- Only unsigned arithmetic is used.

Decomposition:
- Shared package serial_pkg:
  - state enum typedef {IDLE, POP, SEND, GAP};
  - default DATA_WIDTH / HALF_CYCLES constants, reused by the deserializer bench.
- One sub-module is natural: bit_timer, a parameterised down-counter with load and terminal-count pulse. It is instantiated twice: bit period and gap.
- The FSM and shift register stay in byte_serializer.

Test Plan:
1. Reset hold: reset = 0 for 3 cycles with len_in = 5 -> all outputs 0, no dequeue_out. After release, the first pop occurs on the 2nd rising edge.
2. Single byte: len_in = 1, data_in = 8'hA5, enable_in = 1.
   - One dequeue_out pulse.
   - 8 write_out pulses, each 10 cycles high / 10 cycles low.
   - serial_out sequence 1,0,1,0,0,1,0,1.
   - sent_count_out = 1.
   - busy_out falls 300 cycles after the last bit.
3. Back-to-back: len_in held at 8, data_in = 8'h80..8'h87 advancing per pop.
   - 8 bytes serialised in order.
   - Consecutive dequeue_out pulses exactly 462 cycles apart.
   - sent_count_out = 8.
4. Empty / disable:
   - len_in = 0 for 1000 cycles -> no pulse, busy_out = 0.
   - enable_in = 0 during bit 3 of 8'h3C -> byte finishes, then no further pop.
5. Mid-byte reset: assert reset during bit 5 of 8'hFF.
   - Outputs are 0 within the same cycle (asynchronous).
   - sent_count_out = 0.
   - After release, the next byte is serialised from bit 7.
6. Loopback: serial_out/write_out wired to the deserializer input; 8 queued bytes 8'h80..8'h87 -> deserializer reassembles identical values in order.
